multi_cycle_control_unit: RTL

Control FSM for the multiCycleCPU datapath, directly upstream of it; the datapath consumes every control strobe produced here. It sequences each instruction through IF/ID/EXE/MEM/WB, decodes the 6-bit opcode, and asserts datapath enables only in the correct phase. PC advances exactly once per instruction. The CPU-level bench drives CLK and Reset straight through to this block.

---
 rtl/multi_cycle_control_unit.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Control FSM for the multi-cycle CPU datapath. Each instruction is walked
// through IF / ID / EXE / MEM / WB. The 6-bit opcode is decoded, and every
// datapath enable is raised only in the phase where the datapath may act on it.
// The PC advances exactly once per instruction. halt is the exception: it
// never advances the PC, so it refetches itself forever.
//
// Only the state is registered. Every output is combinational from
// (state, opcode, zero, sign). Because of that, an asynchronous reset drops
// every write strobe in the same instant it forces the state to sIF.
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous, active-low; 0 forces state to sIF
//   opcode     in   IR[31:26]; IR holds it stable outside sIF
//   zero       in   ALU result == 0, meaningful in sEXE_BR
//   sign       in   ALU result[31], meaningful in sEXE_BR
//   state      out  current FSM state (also serves as the debug view)
//   PCWre      out  PC write enable
//   IRWre      out  instruction register load
//   InsMemRW   out  instruction memory read
//   ExtSel     out  1 = sign-extend imm16, 0 = zero-extend
//   ALUSrcA    out  1 = shamt, 0 = rs data
//   ALUSrcB    out  1 = extended imm, 0 = rt data
//   ALUOp      out  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 slt
//   RegWre     out  register file write enable
//   RegDst     out  00 = $31, 01 = rt, 10 = rd
//   WrRegDSrc  out  1 = DBData, 0 = PC+4 (jal link value)
//   DBDataSrc  out  1 = data memory, 0 = ALU result
//   mRD        out  data memory read
//   mWR        out  data memory write
//   PCSrc      out  00 = PC+4, 01 = branch target, 10 = jr rs, 11 = jump target
//
// Handshake note: this block has no valid/ready interfaces. The datapath
// samples each strobe on the rising edge that ends the state which raised it.
// -----------------------------------------------------------------------------
module multi_cycle_control_unit #(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           sign,
  output logic [STW-1:0] state,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           ExtSel,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic           WrRegDSrc,
  output logic           DBDataSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [1:0]     PCSrc
);

  // ---------------------------------------------------------------------------
  // State encoding (fixed; visible on the state output)
  // ---------------------------------------------------------------------------
  typedef enum logic [STW-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  // ---------------------------------------------------------------------------
  // Opcodes
  // ---------------------------------------------------------------------------
  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPW-1:0] OP_AND   = 6'b010000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPW-1:0] OP_XORI  = 6'b010011;
  localparam logic [OPW-1:0] OP_OR    = 6'b010100;
  localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OPW-1:0] OP_SLT   = 6'b100111;
  localparam logic [OPW-1:0] OP_SW    = 6'b110000;
  localparam logic [OPW-1:0] OP_LW    = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPW-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OPW-1:0] OP_J     = 6'b111000;
  localparam logic [OPW-1:0] OP_JR    = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RD = 2'b10;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  // ---------------------------------------------------------------------------
  // Opcode decode: instruction class plus the datapath selects, which stay
  // constant for as long as IR holds the opcode.
  // ---------------------------------------------------------------------------
  logic       is_alu, is_lw, is_sw, is_beq, is_bne, is_bltz;
  logic       is_j, is_jr, is_jal, is_halt;
  logic [2:0] dec_alu_op;
  logic       dec_src_a, dec_src_b, dec_ext;
  logic [1:0] dec_reg_dst;

  always_comb begin
    is_alu      = 1'b0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_bltz     = 1'b0;
    is_j        = 1'b0;
    is_jr       = 1'b0;
    is_jal      = 1'b0;
    is_halt     = 1'b0;
    dec_alu_op  = ALU_ADD;
    dec_src_a   = 1'b0;
    dec_src_b   = 1'b0;
    dec_ext     = 1'b1;
    dec_reg_dst = DST_RT;
    unique case (opcode)
      OP_ADD:   begin is_alu = 1'b1; dec_reg_dst = DST_RD; end
      OP_SUB:   begin is_alu = 1'b1; dec_reg_dst = DST_RD; dec_alu_op = ALU_SUB; end
      OP_ADDIU: begin is_alu = 1'b1; dec_src_b = 1'b1; end
      OP_AND:   begin is_alu = 1'b1; dec_reg_dst = DST_RD; dec_alu_op = ALU_AND; end
      OP_ANDI:  begin is_alu = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b0; dec_alu_op = ALU_AND; end
      OP_ORI:   begin is_alu = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b0; dec_alu_op = ALU_OR; end
      OP_XORI:  begin is_alu = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b0; dec_alu_op = ALU_XOR; end
      OP_OR:    begin is_alu = 1'b1; dec_reg_dst = DST_RD; dec_alu_op = ALU_OR; end
      OP_SLL:   begin is_alu = 1'b1; dec_reg_dst = DST_RD; dec_src_a = 1'b1; dec_alu_op = ALU_SLL; end
      OP_SLTI:  begin is_alu = 1'b1; dec_src_b = 1'b1; dec_alu_op = ALU_SLT; end
      OP_SLT:   begin is_alu = 1'b1; dec_reg_dst = DST_RD; dec_alu_op = ALU_SLT; end
      OP_SW:    begin is_sw  = 1'b1; dec_src_b = 1'b1; end
      OP_LW:    begin is_lw  = 1'b1; dec_src_b = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; dec_alu_op = ALU_SUB; end
      OP_BNE:   begin is_bne = 1'b1; dec_alu_op = ALU_SUB; end
      OP_BLTZ:  begin is_bltz = 1'b1; dec_alu_op = ALU_SUB; end
      OP_J:     begin is_j   = 1'b1; dec_reg_dst = DST_RA; end
      OP_JR:    begin is_jr  = 1'b1; dec_reg_dst = DST_RA; end
      OP_JAL:   begin is_jal = 1'b1; dec_reg_dst = DST_RA; end
      OP_HALT:  begin is_halt = 1'b1; dec_reg_dst = DST_RA; end
      default:  begin dec_reg_dst = DST_RA; end  // undefined opcode -> nop
    endcase
  end

  logic is_ls, is_br, br_taken, id_retires;

  assign is_ls    = is_lw | is_sw;
  assign is_br    = is_beq | is_bne | is_bltz;
  assign br_taken = (is_beq & zero) | (is_bne & ~zero) | (is_bltz & sign);
  // j, jr, jal and nop all finish in ID. halt also returns to IF from ID,
  // but it never advances the PC.
  assign id_retires = ~(is_alu | is_ls | is_br | is_halt);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Next state and strobes. Every strobe defaults to 0, so a strobe can be
  // high only in the single state arm that names it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = S_IF;
    PCWre    = 1'b0;
    IRWre    = 1'b0;
    InsMemRW = 1'b0;
    RegWre   = 1'b0;
    mRD      = 1'b0;
    mWR      = 1'b0;
    PCSrc    = PC_SEQ;
    unique case (state_q)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        PCWre  = id_retires;
        RegWre = is_jal;
        if (is_j | is_jal) PCSrc = PC_JUMP;
        else if (is_jr)    PCSrc = PC_JR;
        if (is_alu)     state_d = S_EXE_AL;
        else if (is_ls) state_d = S_EXE_LS;
        else if (is_br) state_d = S_EXE_BR;
        else            state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL: begin
        PCWre   = 1'b1;
        RegWre  = 1'b1;
        state_d = S_IF;
      end
      S_EXE_BR: begin
        PCWre   = 1'b1;
        PCSrc   = br_taken ? PC_BR : PC_SEQ;
        state_d = S_IF;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        mRD     = is_lw;
        mWR     = is_sw;
        PCWre   = is_sw;
        state_d = is_lw ? S_WB_L : S_IF;
      end
      S_WB_L: begin
        PCWre   = 1'b1;
        RegWre  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Datapath selects follow the decode directly. ALUOp is pinned to add in
  // IF so that the reset and fetch view does not depend on the stale IR.
  assign ExtSel    = dec_ext;
  assign ALUSrcA   = dec_src_a;
  assign ALUSrcB   = dec_src_b;
  assign RegDst    = dec_reg_dst;
  assign WrRegDSrc = ~is_jal;
  assign DBDataSrc = is_lw;
  assign ALUOp     = (state_q == S_IF) ? ALU_ADD : dec_alu_op;

endmodule
